pattern_buffer_control: RTL and testbench

PATTERN_BUFFER_CONTROL -- requirements
Module: pattern_buffer_control

---
 rtl/pattern_buffer_control_pkg.sv | 6 +
 rtl/pattern_buffer_control_if.sv | 34 +++
 rtl/pattern_buffer_control_addr_counter.sv | 27 ++
 rtl/pattern_buffer_control.sv | 98 +++++++++
 tb/tb_pattern_buffer_control.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_buffer_control_pkg.sv
// pattern_buffer_control_pkg: playback state encoding and default widths
package pattern_buffer_control_pkg;
   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_DATA_WIDTH = 16;
   typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd1, RUN = 2'd2} state_e;
endpackage

// File: rtl/pattern_buffer_control_if.sv
// pattern_buffer_control_if: host load/playback controls and pattern RAM side
// master drives we/wr_addr/wr_data/load_done/load_len/start/stop;
// slave drives ram_we/ram_wr_addr/ram_wr_data/rd_addr and the status flags
interface pattern_buffer_control_if
   import pattern_buffer_control_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                  we;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  load_done;
   logic [ADDR_WIDTH-1:0] load_len;
   logic                  start;
   logic                  stop;
   logic [1:0]            ram_we;
   logic [ADDR_WIDTH-1:0] ram_wr_addr;
   logic [DATA_WIDTH-1:0] ram_wr_data;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  ready;
   logic                  active;
   logic                  load_complete;
   logic                  preload;
   logic                  active_buffer;
   modport master (
      output we, wr_addr, wr_data, load_done, load_len, start, stop,
      input  ram_we, ram_wr_addr, ram_wr_data, rd_addr, ready, active, load_complete, preload, active_buffer
   );
   modport slave (
      input  we, wr_addr, wr_data, load_done, load_len, start, stop,
      output ram_we, ram_wr_addr, ram_wr_data, rd_addr, ready, active, load_complete, preload, active_buffer
   );
endinterface

// File: rtl/pattern_buffer_control_addr_counter.sv
// pattern_addr_counter: playback read address with load-zero, increment and wrap at len
// clk/reset: clock and async active-high reset; clr: force 0 next cycle;
// en: advance; len: last valid address; addr: current address; wrap: addr==len
module pattern_addr_counter
   import pattern_buffer_control_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  en,
   input  logic [ADDR_WIDTH-1:0] len,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  wrap
);
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   always_comb begin
      wrap = addr_q == len;
      addr_d = clr ? '0 : en ? (wrap ? '0 : addr_q + 1'b1) : addr_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) addr_q <= '0;
      else addr_q <= addr_d;
   end
   assign addr = addr_q;
endmodule

// File: rtl/pattern_buffer_control.sv
// pattern_buffer_control: double-buffered pattern RAM load and gapless playback control
// clk: system clock; reset: async active-high reset;
// bus: host write/load/start/stop in, RAM write port, read address and status out
module pattern_buffer_control
   import pattern_buffer_control_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input logic                    clk,
   input logic                    reset,
   pattern_buffer_control_if.slave bus
);
   state_e                state_q, state_d;
   logic                  active_buffer_q, active_buffer_d;
   logic                  load_complete_q, load_complete_d;
   logic                  preload_q, preload_d;
   logic                  ready_q, ready_d;
   logic                  active_q, active_d;
   logic [1:0]            ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_wr_addr_q, ram_wr_addr_d;
   logic [DATA_WIDTH-1:0] ram_wr_data_q, ram_wr_data_d;
   logic [ADDR_WIDTH-1:0] active_len_q, active_len_d;
   logic [ADDR_WIDTH-1:0] pending_len_q, pending_len_d;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  we_ok, ld_ok, wrap, swap, cnt_clr, cnt_en;
   always_comb begin
      we_ok = bus.we && !load_complete_q;
      ld_ok = bus.load_done && !load_complete_q;
      // in RUN the swap waits for the wrap so the new pattern follows without a gap
      swap = load_complete_q && (state_q == RUN ? wrap && !bus.stop : 1'b1);
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = load_complete_q ? READY : IDLE;
         READY:   state_d = (!load_complete_q && bus.start && !bus.stop) ? RUN : READY;
         RUN:     state_d = bus.stop ? READY : RUN;
         default: state_d = IDLE;
      endcase
      active_buffer_d = active_buffer_q ^ swap;
      active_len_d = swap ? pending_len_q : active_len_q;
      load_complete_d = swap ? 1'b0 : (ld_ok || load_complete_q);
      pending_len_d = ld_ok ? bus.load_len : pending_len_q;
      preload_d = ld_ok ? 1'b0 : (we_ok || preload_q);
      ram_we_d = we_ok ? (active_buffer_q ? 2'b01 : 2'b10) : 2'b00;
      ram_wr_addr_d = bus.wr_addr;
      ram_wr_data_d = bus.wr_data;
      ready_d = state_d == READY;
      active_d = state_d == RUN;
      // address holds 0 on the first RUN cycle and only advances while already running
      cnt_clr = state_d != RUN;
      cnt_en = state_q == RUN;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         active_buffer_q <= 1'b0;
         load_complete_q <= 1'b0;
         preload_q       <= 1'b0;
         ready_q         <= 1'b0;
         active_q        <= 1'b0;
         ram_we_q        <= 2'b00;
         ram_wr_addr_q   <= '0;
         ram_wr_data_q   <= '0;
         active_len_q    <= '0;
         pending_len_q   <= '0;
      end else begin
         state_q         <= state_d;
         active_buffer_q <= active_buffer_d;
         load_complete_q <= load_complete_d;
         preload_q       <= preload_d;
         ready_q         <= ready_d;
         active_q        <= active_d;
         ram_we_q        <= ram_we_d;
         ram_wr_addr_q   <= ram_wr_addr_d;
         ram_wr_data_q   <= ram_wr_data_d;
         active_len_q    <= active_len_d;
         pending_len_q   <= pending_len_d;
      end
   end
   pattern_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .len   (active_len_q),
      .addr  (rd_addr),
      .wrap  (wrap)
   );
   assign bus.ram_we        = ram_we_q;
   assign bus.ram_wr_addr   = ram_wr_addr_q;
   assign bus.ram_wr_data   = ram_wr_data_q;
   assign bus.rd_addr       = rd_addr;
   assign bus.ready         = ready_q;
   assign bus.active        = active_q;
   assign bus.load_complete = load_complete_q;
   assign bus.preload       = preload_q;
   assign bus.active_buffer = active_buffer_q;
endmodule

// File: tb/tb_pattern_buffer_control.sv
// tb_pattern_buffer_control: directed load, playback, swap, stop and reset scenarios
module tb_pattern_buffer_control;
   logic clk = 1'b0;
   logic reset;
   int vectors = 0;
   int errors = 0;
   logic [4:0] st;
   pattern_buffer_control_if bus ();
   pattern_buffer_control dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   // st = {ready, active, load_complete, preload, active_buffer}
   assign st = {bus.ready, bus.active, bus.load_complete, bus.preload, bus.active_buffer};

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet;
      bus.we = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.load_done = 1'b0;
      bus.load_len = '0;
      bus.start = 1'b0;
      bus.stop = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      quiet();
      #1;
      vectors++;
      if ({bus.ram_we, bus.rd_addr, st} !== 17'd0) begin
         errors++;
         $display("FAIL reset_before_clk: got %h want 0", {bus.ram_we, bus.rd_addr, st});
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      vectors++;
      if ({bus.ram_we, bus.rd_addr, st} !== 17'd0) begin
         errors++;
         $display("FAIL reset_state: got %h want 0", {bus.ram_we, bus.rd_addr, st});
      end
   endtask

   task automatic test_load;
      for (int i = 0; i < 4; i++) begin
         bus.we = 1'b1;
         bus.wr_addr = 10'(i);
         bus.wr_data = 16'(16'hA0 + i);
         cyc();
         vectors++;
         if ({bus.ram_we, bus.ram_wr_addr, bus.ram_wr_data, st} !== {2'b10, 10'(i), 16'(16'hA0 + i), 5'b00010}) begin
            errors++;
            $display("FAIL load_write[%0d]: ram_we=%b addr=%0d data=%h st=%b want 10/%0d/%h/00010",
                     i, bus.ram_we, bus.ram_wr_addr, bus.ram_wr_data, st, i, 16'hA0 + i);
         end
      end
      quiet();
      bus.load_done = 1'b1;
      bus.load_len = 10'd3;
      cyc();
      vectors++;
      if ({bus.ram_we, st} !== {2'b00, 5'b00100}) begin
         errors++;
         $display("FAIL load_done: ram_we=%b st=%b want 00/00100", bus.ram_we, st);
      end
      quiet();
      cyc();
      vectors++;
      if ({bus.rd_addr, st} !== {10'd0, 5'b10001}) begin
         errors++;
         $display("FAIL idle_swap: rd=%0d st=%b want 0/10001", bus.rd_addr, st);
      end
   endtask

   task automatic test_run;
      logic [9:0] exp_rd [5] = '{10'd1, 10'd2, 10'd3, 10'd0, 10'd1};
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      vectors++;
      if ({bus.rd_addr, st} !== {10'd0, 5'b01001}) begin
         errors++;
         $display("FAIL run_start: rd=%0d st=%b want 0/01001", bus.rd_addr, st);
      end
      for (int i = 0; i < 5; i++) begin
         cyc();
         vectors++;
         if (bus.rd_addr !== exp_rd[i]) begin
            errors++;
            $display("FAIL run_seq[%0d]: rd=%0d want %0d", i, bus.rd_addr, exp_rd[i]);
         end
      end
   endtask

   task automatic test_swap_in_run;
      logic [9:0] exp_rd [9] = '{10'd2, 10'd3, 10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd0};
      logic [4:0] exp_st [9] = '{5'b01101, 5'b01101, 5'b01000, 5'b01000, 5'b01000,
                                 5'b01000, 5'b01000, 5'b01000, 5'b01000};
      for (int i = 0; i < 2; i++) begin
         bus.we = 1'b1;
         bus.wr_addr = 10'(i);
         bus.wr_data = 16'(16'hB0 + i);
         cyc();
         vectors++;
         if ({bus.ram_we, bus.rd_addr, st} !== {2'b01, 10'(i + 2), 5'b01011}) begin
            errors++;
            $display("FAIL run_load_write[%0d]: ram_we=%b rd=%0d st=%b want 01/%0d/01011",
                     i, bus.ram_we, bus.rd_addr, st, i + 2);
         end
      end
      quiet();
      bus.load_done = 1'b1;
      bus.load_len = 10'd5;
      cyc();
      vectors++;
      if ({bus.rd_addr, st} !== {10'd0, 5'b01101}) begin
         errors++;
         $display("FAIL run_load_done: rd=%0d st=%b want 0/01101", bus.rd_addr, st);
      end
      bus.load_done = 1'b1;
      bus.load_len = 10'd7;
      bus.we = 1'b1;
      bus.wr_addr = 10'd7;
      cyc();
      vectors++;
      if ({bus.ram_we, bus.rd_addr, st} !== {2'b00, 10'd1, 5'b01101}) begin
         errors++;
         $display("FAIL ignore_while_pending: ram_we=%b rd=%0d st=%b want 00/1/01101", bus.ram_we, bus.rd_addr, st);
      end
      quiet();
      for (int i = 0; i < 9; i++) begin
         cyc();
         vectors++;
         if ({bus.rd_addr, st} !== {exp_rd[i], exp_st[i]}) begin
            errors++;
            $display("FAIL wrap_swap[%0d]: rd=%0d st=%b want %0d/%b", i, bus.rd_addr, st, exp_rd[i], exp_st[i]);
         end
      end
   endtask

   task automatic test_stop_at_wrap;
      bus.we = 1'b1;
      cyc();
      vectors++;
      if ({bus.ram_we, bus.rd_addr, st} !== {2'b10, 10'd1, 5'b01010}) begin
         errors++;
         $display("FAIL stop_load_write: ram_we=%b rd=%0d st=%b want 10/1/01010", bus.ram_we, bus.rd_addr, st);
      end
      quiet();
      bus.load_done = 1'b1;
      bus.load_len = 10'd2;
      cyc();
      quiet();
      repeat (3) cyc();
      vectors++;
      if ({bus.rd_addr, st} !== {10'd5, 5'b01100}) begin
         errors++;
         $display("FAIL before_wrap: rd=%0d st=%b want 5/01100", bus.rd_addr, st);
      end
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      vectors++;
      if ({bus.rd_addr, st} !== {10'd0, 5'b10100}) begin
         errors++;
         $display("FAIL stop_wins_wrap: rd=%0d st=%b want 0/10100", bus.rd_addr, st);
      end
      cyc();
      vectors++;
      if ({bus.rd_addr, st} !== {10'd0, 5'b10001}) begin
         errors++;
         $display("FAIL ready_swap: rd=%0d st=%b want 0/10001", bus.rd_addr, st);
      end
      bus.start = 1'b1;
      bus.stop = 1'b1;
      cyc();
      vectors++;
      if ({bus.rd_addr, st} !== {10'd0, 5'b10001}) begin
         errors++;
         $display("FAIL start_stop_same: rd=%0d st=%b want 0/10001", bus.rd_addr, st);
      end
      bus.stop = 1'b0;
      cyc();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({bus.rd_addr, st} !== {10'(i % 3), 5'b01001}) begin
            errors++;
            $display("FAIL len2_seq[%0d]: rd=%0d st=%b want %0d/01001", i, bus.rd_addr, st, i % 3);
         end
         cyc();
      end
   endtask

   task automatic test_len_zero;
      bus.stop = 1'b1;
      cyc();
      quiet();
      bus.we = 1'b1;
      bus.load_done = 1'b1;
      bus.load_len = 10'd0;
      cyc();
      quiet();
      vectors++;
      if ({bus.ram_we, st} !== {2'b01, 5'b10101}) begin
         errors++;
         $display("FAIL len0_load: ram_we=%b st=%b want 01/10101", bus.ram_we, st);
      end
      cyc();
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({bus.rd_addr, st} !== {10'd0, 5'b01000}) begin
            errors++;
            $display("FAIL len0_replay[%0d]: rd=%0d st=%b want 0/01000", i, bus.rd_addr, st);
         end
         cyc();
      end
   endtask

   task automatic test_async_reset;
      bus.we = 1'b1;
      bus.load_done = 1'b1;
      bus.load_len = 10'd4;
      cyc();
      quiet();
      vectors++;
      if ({bus.ram_we, st} !== {2'b10, 5'b01100}) begin
         errors++;
         $display("FAIL pre_reset: ram_we=%b st=%b want 10/01100", bus.ram_we, st);
      end
      #3 reset = 1'b1;
      #1;
      vectors++;
      if ({bus.ram_we, bus.rd_addr, st} !== 17'd0) begin
         errors++;
         $display("FAIL async_reset: got %h want 0", {bus.ram_we, bus.rd_addr, st});
      end
      #2 reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         vectors++;
         if ({bus.ram_we, bus.rd_addr, st} !== 17'd0) begin
            errors++;
            $display("FAIL pending_discarded[%0d]: got %h want 0", i, {bus.ram_we, bus.rd_addr, st});
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_run();
      test_swap_in_run();
      test_stop_at_wrap();
      test_len_zero();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
